// File: rtl/mips_div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU. It runs 32 iterations and then one
// sign/zero fix-up cycle. The quotient is held on lo and the remainder on hi.
module mips_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clock_enable,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);
    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    iter_reg;
    logic [WIDTH-1:0] quot_reg, rem_reg, dsor_reg, raw_dvd_reg;
    logic             dvd_neg_reg, dsor_neg_reg, dsor_zero_reg;
    logic [WIDTH-1:0] lo_reg, hi_reg;
    logic             dbz_reg;

    logic             accept;
    logic             dvd_neg, dsor_neg;
    logic [WIDTH-1:0] dvd_mag, dsor_mag;
    logic [WIDTH:0]   rem_shift;
    logic             trial_ok;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (iter_reg == LAST_ITER) state_next = FIX;
            end
            FIX:  state_next = DONE;
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The partial remainder is always below the divisor.
    // The subtract therefore only needs WIDTH bits once the 33-bit compare has passed.
    always_comb begin
        dvd_neg   = is_signed & dividend[WIDTH-1];
        dsor_neg  = is_signed & divisor[WIDTH-1];
        dvd_mag   = dvd_neg  ? -dividend : dividend;
        dsor_mag  = dsor_neg ? -divisor  : divisor;
        rem_shift = {rem_reg, quot_reg[WIDTH-1]};
        trial_ok  = (rem_shift >= {1'b0, dsor_reg});
        trial     = rem_shift[WIDTH-1:0] - dsor_reg;
        quot_fix  = (dvd_neg_reg ^ dsor_neg_reg) ? -quot_reg : quot_reg;
        rem_fix   = dvd_neg_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            iter_reg      <= '0;
            quot_reg      <= '0;
            rem_reg       <= '0;
            dsor_reg      <= '0;
            raw_dvd_reg   <= '0;
            dvd_neg_reg   <= 1'b0;
            dsor_neg_reg  <= 1'b0;
            dsor_zero_reg <= 1'b0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            dbz_reg       <= 1'b0;
        end else if (clock_enable) begin
            state_reg <= state_next;
            if (accept) begin
                dvd_neg_reg   <= dvd_neg;
                dsor_neg_reg  <= dsor_neg;
                dsor_zero_reg <= (divisor == '0);
                quot_reg      <= dvd_mag;
                dsor_reg      <= dsor_mag;
                raw_dvd_reg   <= dividend;
                rem_reg       <= '0;
                iter_reg      <= '0;
            end else if (state_reg == RUN) begin
                quot_reg <= {quot_reg[WIDTH-2:0], trial_ok};
                rem_reg  <= trial_ok ? trial : rem_shift[WIDTH-1:0];
                iter_reg <= iter_reg + CW'(1);
            end else if (state_reg == FIX) begin
                // A zero divisor returns all-ones and passes the dividend through unchanged.
                if (dsor_zero_reg) begin
                    lo_reg  <= '1;
                    hi_reg  <= raw_dvd_reg;
                    dbz_reg <= 1'b1;
                end else begin
                    lo_reg  <= quot_fix;
                    hi_reg  <= rem_fix;
                    dbz_reg <= 1'b0;
                end
            end
        end
    end

    assign busy        = (state_reg == RUN) || (state_reg == FIX);
    assign done        = (state_reg == DONE);
    assign lo          = lo_reg;
    assign hi          = hi_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_mips_div_unit.sv
// Bench for mips_div_unit. It compares the DUT every cycle against a cycle-count reference
// model, and also runs directed cases that carry literal expectations.
module tb_mips_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clock_enable = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] lo, hi;

    int vectors = 0;
    int miscompares = 0;
    int pe = 0;
    int last_start = 0;
    bit checking = 1'b0;

    mips_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clock_enable(clock_enable), .start(start),
        .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;

    // The reference model tracks the phase as the number of enabled edges since accept.
    // Phases 0..32 are busy, phase 33 is done, and -1 is idle.
    int          m_phase = -1;
    logic [31:0] m_lo = '0, m_hi = '0;
    logic        m_dbz = 1'b0;
    logic [31:0] p_lo, p_hi, p_a, p_b;
    logic        p_dbz, p_s;

    function automatic logic [64:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a, 1'b1};
        if (!s) return {a / b, a % b, 1'b0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0], 1'b0};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= -1;
            m_lo    <= '0;
            m_hi    <= '0;
            m_dbz   <= 1'b0;
        end else if (clock_enable) begin
            if ((m_phase < 0 || m_phase == 33) && start) begin
                m_phase <= 0;
                {p_lo, p_hi, p_dbz} <= model_div(is_signed, dividend, divisor);
                p_s <= is_signed;
                p_a <= dividend;
                p_b <= divisor;
            end else if (m_phase >= 0 && m_phase < 32) begin
                m_phase <= m_phase + 1;
            end else if (m_phase == 32) begin
                m_phase <= 33;
                m_lo    <= p_lo;
                m_hi    <= p_hi;
                m_dbz   <= p_dbz;
                $display("%s %h / %h -> lo=%h hi=%h dz=%b", p_s ? "DIV " : "DIVU", p_a, p_b, p_lo, p_hi, p_dbz);
            end else begin
                m_phase <= -1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if (busy !== (m_phase >= 0 && m_phase <= 32) || done !== (m_phase == 33) ||
                lo !== m_lo || hi !== m_hi || div_by_zero !== m_dbz) begin
                miscompares++;
                $display("FAIL cycle t=%0t: busy=%b done=%b lo=%h hi=%h dz=%b, required busy=%b done=%b lo=%h hi=%h dz=%b",
                         $time, busy, done, lo, hi, div_by_zero,
                         (m_phase >= 0 && m_phase <= 32), (m_phase == 33), m_lo, m_hi, m_dbz);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    // Call at a negedge. The accept edge follows, and the operands are scrambled after it.
    task automatic pulse_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        last_start = pe;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        is_signed = 1'($urandom_range(1));
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic wait_done(output int n);
        while (!done && (pe - last_start) < 100) @(negedge clk);
        n = pe - last_start;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: no done pulse after %0d edges, required within 100", n);
        end
    endtask

    task automatic directed(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] el, input logic [31:0] eh, input logic ez);
        int n;
        pulse_start(s, a, b);
        wait_done(n);
        check({name, "_latency"}, n, 32'd34);
        check({name, "_lo"}, lo, el);
        check({name, "_hi"}, hi, eh);
        check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        check({name, "_model_lo"}, m_lo, el);
        check({name, "_model_hi"}, m_hi, eh);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int dcnt;
        bit seen;

        // Two reset edges with the enable low show that reset takes priority over it.
        @(negedge clk);
        @(negedge clk);
        checking = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        clock_enable = 1'b1;

        directed("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        directed("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        directed("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        directed("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        directed("divu_zero", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        directed("div_zero", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);
        directed("dbz_clear", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);

        // Reset on the 10th edge after accept aborts the operation and clears the results.
        pulse_start(1'b0, 32'd1000, 32'd3);
        while (pe - last_start < 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_lo", lo, 32'd0);
        check("rstmid_hi", hi, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("rstmid_no_done", {31'd0, seen}, 32'd0);

        // A start pulse during RUN is ignored. A start during DONE is accepted back to back.
        pulse_start(1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        is_signed = 1'b1;
        dividend  = 32'd5;
        divisor   = 32'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ignored_latency", n, 32'd34);
        check("ignored_lo", lo, 32'd14);
        check("ignored_hi", hi, 32'd2);
        pulse_start(1'b0, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        check("b2b_latency", n, 32'd34);
        check("b2b_lo", lo, 32'h0FFF_FFFF);
        check("b2b_hi", hi, 32'hF);
        @(negedge clk);

        // Stall the enable for 5 cycles in RUN and for 3 cycles in DONE.
        pulse_start(1'b1, 32'hFFFF_FFF9, 32'd2);
        while (pe - last_start < 10) @(negedge clk);
        clock_enable = 1'b0;
        repeat (5) @(negedge clk);
        clock_enable = 1'b1;
        wait_done(n);
        check("stall_latency", n, 32'd39);
        clock_enable = 1'b0;
        dcnt = 1;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        clock_enable = 1'b1;
        @(negedge clk);
        check("stall_done_len", dcnt, 32'd4);
        check("stall_done_fall", {31'd0, done}, 32'd0);
        check("stall_lo", lo, 32'hFFFF_FFFD);
        check("stall_hi", hi, 32'hFFFF_FFFF);

        // Random traffic uses enable stalls, ignored starts, back-to-back accepts and rare resets.
        repeat (3000) begin
            clock_enable = ($urandom_range(9) != 0);
            start        = ($urandom_range(3) == 0);
            reset        = ($urandom_range(499) == 0);
            is_signed    = 1'($urandom_range(1));
            dividend     = rnd_op();
            divisor      = rnd_op();
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
        clock_enable = 1'b1;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
